// File: rtl/tweet_pkg.sv
// Shared state encodings and default constants for the tweet buffer and its receiver.
package tweet_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, CLEAR} state_t;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

  localparam int         TWEET_CLK_DIV = 5208;
  localparam int         TWEET_DEPTH   = 160;
  localparam logic [7:0] TWEET_BS_CODE = 8'h08;

endpackage

// File: rtl/uart_rx_sampler.sv
// Mid-bit sampling serial receiver: two-flop synchroniser, start qualification, LSB-first data.
// TWEET_PARITY_EN adds an even-parity bit between the last data bit and the stop bit.
module uart_rx_sampler
  import tweet_pkg::*;
#(
  parameter int CLK_DIV = TWEET_CLK_DIV,
  parameter int DATA_W  = 8
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              rx,
  output logic              byte_valid,
  output logic [DATA_W-1:0] rx_byte,
  output logic              rx_err
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  rx_state_t         rx_state;
  logic              rx_p0, rx_p1, rx_p2;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift;
  logic              bit_tick;

  assign bit_tick = (cnt == LAST_CNT);
  assign rx_byte  = shift;

  // Stage p0/p1 synchronise the line; p2 keeps the previous value for falling-edge detect.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rx_state == RX_DATA && bit_tick)
      shift <= {rx_p1, shift[DATA_W-1:1]};
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
      cnt        <= cnt + 1'b1;
      case (rx_state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_p2 && !rx_p1)
            rx_state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_CNT) begin
            cnt      <= '0;
            bit_idx  <= '0;
            rx_state <= rx_p1 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (bit_tick) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT)
`ifdef TWEET_PARITY_EN
              rx_state <= RX_PAR;
`else
              rx_state <= RX_STOP;
`endif
          end
        end
`ifdef TWEET_PARITY_EN
        RX_PAR: begin
          if (bit_tick) begin
            cnt <= '0;
            if (rx_p1 != ^shift) begin
              rx_err   <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_STOP;
            end
          end
        end
`endif
        RX_STOP: begin
          if (bit_tick) begin
            cnt      <= '0;
            rx_state <= RX_IDLE;
            if (rx_p1)
              byte_valid <= 1'b1;
            else
              rx_err <= 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tweet_buffer.sv
// Serial character buffer with backspace editing, clear sweep and valid/ready playback.
// Optional TWEET_PARITY_EN (in uart_rx_sampler) enables even parity on received frames.
module tweet_buffer
  import tweet_pkg::*;
#(
  parameter int                CLK_DIV = TWEET_CLK_DIV,
  parameter int                DEPTH   = TWEET_DEPTH,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] BS_CODE = DATA_W'(TWEET_BS_CODE)
) (
  input  logic                       sysclk,
  input  logic                       reset,
  input  logic                       rx,
  input  logic                       play,
  input  logic                       clear,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       busy,
  output logic                       rx_err,
  output logic                       rx_drop
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr, clr_ptr;
  logic              vld_p0;
  logic              byte_valid;
  logic [DATA_W-1:0] rx_byte;
  logic              is_bs, at_last, handshake;
  logic              mem_we;
  logic [PW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  uart_rx_sampler #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W)
  ) u_rx (
    .sysclk     (sysclk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .rx_err     (rx_err)
  );

  assign is_bs     = (rx_byte == BS_CODE);
  assign handshake = tx_valid && tx_ready;
  assign at_last   = (CW'(rd_ptr) == count - 1'b1);
  assign full      = (count == CW'(DEPTH));
  assign busy      = (state != IDLE);

  // The clear sweep owns the write port; otherwise a stored character appends at count.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = PW'(count);
    mem_wdata = rx_byte;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_ptr;
      mem_wdata = '0;
    end else if (state == IDLE && byte_valid && !clear && !play && !is_bs && !full) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (mem_we)
      mem[mem_addr] <= mem_wdata;
  end

  // vld_p0 marks a read issued this cycle; tx_data/tx_valid form the registered read stage.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      clr_ptr  <= '0;
      vld_p0   <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      rx_drop  <= 1'b0;
    end else begin
      rx_drop <= 1'b0;
      if (clear && state != CLEAR) begin
        state    <= CLEAR;
        count    <= '0;
        clr_ptr  <= '0;
        vld_p0   <= 1'b0;
        tx_valid <= 1'b0;
        rx_drop  <= byte_valid;
      end else begin
        case (state)
          IDLE: begin
            if (play && count != '0) begin
              state   <= PLAY;
              rd_ptr  <= '0;
              vld_p0  <= 1'b1;
              rx_drop <= byte_valid;
            end else if (byte_valid) begin
              if (is_bs) begin
                if (count != '0)
                  count <= count - 1'b1;
              end else if (full) begin
                rx_drop <= 1'b1;
              end else begin
                count <= count + 1'b1;
              end
            end
          end
          PLAY: begin
            rx_drop <= byte_valid;
            if (vld_p0) begin
              tx_data  <= mem[rd_ptr];
              tx_valid <= 1'b1;
              vld_p0   <= 1'b0;
            end else if (handshake) begin
              tx_valid <= 1'b0;
              if (at_last) begin
                state <= IDLE;
              end else begin
                rd_ptr <= rd_ptr + 1'b1;
                vld_p0 <= 1'b1;
              end
            end
          end
          CLEAR: begin
            rx_drop <= byte_valid;
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == LAST_PTR)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
